// File: rtl/seq_index_prefix.sv
// Sequencer for the DD/FD-prefixed (IX/IY) decoder: prefix mode, opcode latch, XPT phase and displacement.
// Optional XPT watchdog is enabled by defining SEQ_XPT_WATCHDOG_EN; otherwise XPT wraps and xpt_fault is 0.
module seq_index_prefix #(
  parameter int unsigned XPT_WIDTH  = 5,
  parameter int unsigned DISP_WIDTH = 16,
  parameter logic [7:0]  PREFIX_X   = 8'hDD,
  parameter logic [7:0]  PREFIX_Y   = 8'hFD
) (
  input  logic                  clock,
  input  logic                  not_reset,
  input  logic                  fetch_valid,
  input  logic [7:0]            fetch_byte,
  input  logic                  mem_ready,
  input  logic                  disp_load,
  input  logic                  PR_Reset_XPT,
  input  logic                  P2_Reset_XIX,
  input  logic                  P2_Reset_XIY,
  input  logic                  P2_Set_CM1,
  output logic                  not_enable,
  output logic                  is_Y,
  output logic [XPT_WIDTH-1:0]  XPT,
  output logic [XPT_WIDTH-1:0]  notXPT,
  output logic [7:0]            Source,
  output logic [7:0]            notSource,
  output logic [DISP_WIDTH-1:0] disp,
  output logic                  prefix_active,
  output logic                  xpt_fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PFX  = 2'd1,
    EXEC = 2'd2
  } state_e;

  localparam logic [XPT_WIDTH-1:0] XPT_ONE = {{(XPT_WIDTH-1){1'b0}}, 1'b1};

  state_e                stateQ, stateD;
  logic                  isYQ, isYD;
  logic [XPT_WIDTH-1:0]  xptQ, xptD;
  logic [XPT_WIDTH-1:0]  notXptQ;
  logic [7:0]            sourceQ, sourceD;
  logic [7:0]            notSourceQ;
  logic [DISP_WIDTH-1:0] dispQ, dispD;
  logic                  notEnableQ;
  logic                  prefixActiveQ;
  logic                  faultD;

  logic                  isPrefixByte;
  logic                  endRequest;
  logic [DISP_WIDTH-1:0] dispExtended;

  assign isPrefixByte = (fetch_byte == PREFIX_X) || (fetch_byte == PREFIX_Y);
  // Only the reset request for the mode we are actually in ends the instruction.
  assign endRequest   = (P2_Reset_XIX && !isYQ) || (P2_Reset_XIY && isYQ);
  assign dispExtended = {{(DISP_WIDTH-8){fetch_byte[7]}}, fetch_byte};

`ifdef SEQ_XPT_WATCHDOG_EN
  localparam logic [XPT_WIDTH-1:0] XPT_MAX = {XPT_WIDTH{1'b1}};
`endif

  always_comb begin
    stateD  = stateQ;
    isYD    = isYQ;
    xptD    = xptQ;
    sourceD = sourceQ;
    dispD   = dispQ;
    faultD  = 1'b0;

    case (stateQ)
      IDLE: begin
        if (fetch_valid && isPrefixByte) begin
          stateD = PFX;
          isYD   = (fetch_byte == PREFIX_Y);
          dispD  = '0;
        end
      end

      PFX: begin
        if (fetch_valid) begin
          if (isPrefixByte) begin
            isYD = (fetch_byte == PREFIX_Y);
          end else begin
            stateD  = EXEC;
            sourceD = fetch_byte;
            xptD    = '0;
          end
        end
      end

      EXEC: begin
        if (disp_load && fetch_valid) begin
          dispD = dispExtended;
        end
        if (endRequest) begin
          stateD = IDLE;
          xptD   = '0;
        end else if (P2_Set_CM1) begin
          stateD = PFX;
          xptD   = '0;
        end else if (PR_Reset_XPT) begin
          xptD = '0;
        end else if (mem_ready) begin
`ifdef SEQ_XPT_WATCHDOG_EN
          if (xptQ == XPT_MAX) begin
            stateD = IDLE;
            xptD   = '0;
            faultD = 1'b1;
          end else begin
            xptD = xptQ + XPT_ONE;
          end
`else
          xptD = xptQ + XPT_ONE;
`endif
        end
      end

      default: begin
        stateD = IDLE;
        xptD   = '0;
      end
    endcase
  end

  // Decoder-facing outputs are derived from next state so every output is a flop.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      stateQ        <= IDLE;
      isYQ          <= 1'b0;
      xptQ          <= '0;
      notXptQ       <= '1;
      sourceQ       <= 8'h00;
      notSourceQ    <= 8'hFF;
      dispQ         <= '0;
      notEnableQ    <= 1'b1;
      prefixActiveQ <= 1'b0;
    end else begin
      stateQ        <= stateD;
      isYQ          <= isYD;
      xptQ          <= xptD;
      notXptQ       <= ~xptD;
      sourceQ       <= sourceD;
      notSourceQ    <= ~sourceD;
      dispQ         <= dispD;
      notEnableQ    <= (stateD != EXEC);
      prefixActiveQ <= (stateD != IDLE);
    end
  end

`ifdef SEQ_XPT_WATCHDOG_EN
  logic faultQ;

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      faultQ <= 1'b0;
    end else begin
      faultQ <= faultD;
    end
  end

  assign xpt_fault = faultQ;
`else
  logic unusedFault;
  assign unusedFault = faultD;
  assign xpt_fault   = 1'b0;
`endif

  assign not_enable    = notEnableQ;
  assign is_Y          = isYQ;
  assign XPT           = xptQ;
  assign notXPT        = notXptQ;
  assign Source        = sourceQ;
  assign notSource     = notSourceQ;
  assign disp          = dispQ;
  assign prefix_active = prefixActiveQ;

endmodule
